// File: rtl/tpu_matmul_sequencer.sv
// Single-tile matmul sequencer: weight pop, reload, UB stream, result writeback.
// Optional abort/aborted ports are enabled by defining SEQ_ABORT_EN.
module tpu_matmul_sequencer #(
  parameter int ADDRESSSIZE   = 10,
  parameter int RELOAD_CYCLES = 16,
  parameter int PIPE_LATENCY  = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE:0]   num_rows,
  input  logic [ADDRESSSIZE-1:0] ub_base_addr,
  input  logic [ADDRESSSIZE-1:0] res_base_addr,
  input  logic                   fifo_empty,
`ifdef SEQ_ABORT_EN
  input  logic                   abort,
  output logic                   aborted,
`endif
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   ub_read_valid,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   busy,
  output logic                   done
);

  localparam int NW = ADDRESSSIZE + 1;
  localparam int RW = $clog2(RELOAD_CYCLES + 1);
  localparam int CW = (RW > NW) ? RW : NW;
  localparam int LW = $clog2(PIPE_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_W, S_FETCH, S_RELOAD,
    S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [NW-1:0]          r_n;
  logic [ADDRESSSIZE-1:0] r_ub_base;
  logic [ADDRESSSIZE-1:0] r_res_base;
  logic [CW-1:0]          r_cnt;
  logic [LW-1:0]          r_lat;
  logic                   r_lat_run;
  logic [NW-1:0]          r_wcnt;
  logic [ADDRESSSIZE-1:0] r_ub_last;
  logic [ADDRESSSIZE-1:0] r_res_last;

  logic                   w_abort;
  logic                   w_wr;
  logic                   w_wr_last;
  logic                   w_rl_last;
  logic                   w_st_last;
  logic [ADDRESSSIZE-1:0] w_ub_addr;
  logic [ADDRESSSIZE-1:0] w_res_addr;

`ifdef SEQ_ABORT_EN
  logic r_aborted;
  assign w_abort = abort && (r_state != S_IDLE);
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // Write side is keyed off the latency counter, not the FSM state
  assign w_wr      = r_lat_run && (r_lat == LW'(PIPE_LATENCY))
                     && (r_wcnt < r_n);
  assign w_wr_last = w_wr && (r_wcnt == r_n - 1'b1);
  assign w_rl_last = (r_cnt == CW'(RELOAD_CYCLES - 1));
  assign w_st_last = (r_cnt == (CW'(r_n) - CW'(1)));
  assign w_ub_addr  = r_ub_base + r_cnt[ADDRESSSIZE-1:0];
  assign w_res_addr = r_res_base + r_wcnt[ADDRESSSIZE-1:0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_rows == '0)  w_next = S_DONE;
          else if (fifo_empty) w_next = S_WAIT_W;
          else                 w_next = S_FETCH;
        end
      end
      S_WAIT_W: if (!fifo_empty) w_next = S_FETCH;
      S_FETCH:  w_next = S_RELOAD;
      S_RELOAD: if (w_rl_last) w_next = S_STREAM;
      S_STREAM: if (w_st_last) w_next = S_DRAIN;
      S_DRAIN:  if (w_wr_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_ub_base  <= '0;
      r_res_base <= '0;
      r_cnt      <= '0;
      r_lat      <= '0;
      r_lat_run  <= 1'b0;
      r_wcnt     <= '0;
      r_ub_last  <= '0;
      r_res_last <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_n        <= num_rows;
        r_ub_base  <= ub_base_addr;
        r_res_base <= res_base_addr;
      end
      if ((r_state == S_RELOAD || r_state == S_STREAM)
          && w_next == r_state)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
      if (r_state == S_STREAM)
        r_ub_last <= w_ub_addr;
      if (r_state == S_RELOAD && w_next == S_STREAM) begin
        r_lat_run <= 1'b1;
        r_lat     <= '0;
        r_wcnt    <= '0;
      end else if (r_lat_run && r_lat != LW'(PIPE_LATENCY)) begin
        r_lat <= r_lat + 1'b1;
      end
      if (w_wr) begin
        r_wcnt     <= r_wcnt + 1'b1;
        r_res_last <= w_res_addr;
      end
      if (w_abort || w_wr_last)
        r_lat_run <= 1'b0;
    end
  end

`ifdef SEQ_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_aborted <= 1'b0;
    else     r_aborted <= w_abort;
  end
`endif

  assign fifo_read_enable = (r_state == S_FETCH);
  assign we_rl            = (r_state == S_RELOAD);
  assign ub_read_valid    = (r_state == S_STREAM);
  assign ub_address       = ub_read_valid ? w_ub_addr : r_ub_last;
  assign res_write_enable = w_wr;
  assign res_address      = w_wr ? w_res_addr : r_res_last;
  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);

endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// Directed bench for tpu_matmul_sequencer with default parameters.
// Cycle c is the clock period following edge c-1; start is sampled at edge 0.
module tb_tpu_matmul_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [10:0] num_rows;
  logic [9:0] ub_base_addr;
  logic [9:0] res_base_addr;
  logic       fifo_empty;
  logic       fifo_read_enable;
  logic       we_rl;
  logic [9:0] ub_address;
  logic       ub_read_valid;
  logic       res_write_enable;
  logic [9:0] res_address;
  logic       busy;
  logic       done;
`ifdef SEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] hold_ub;
  logic [9:0] hold_res;

  always #5 clk = ~clk;

  tpu_matmul_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_rows         (num_rows),
    .ub_base_addr     (ub_base_addr),
    .res_base_addr    (res_base_addr),
    .fifo_empty       (fifo_empty),
`ifdef SEQ_ABORT_EN
    .abort            (abort),
    .aborted          (aborted),
`endif
    .fifo_read_enable (fifo_read_enable),
    .we_rl            (we_rl),
    .ub_address       (ub_address),
    .ub_read_valid    (ub_read_valid),
    .res_write_enable (res_write_enable),
    .res_address      (res_address),
    .busy             (busy),
    .done             (done)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tile(
    input string name, input int n,
    input logic [9:0] ubb, input logic [9:0] resb,
    input int w, input bit restart,
    input int f, input int rl_lo, input int rl_hi,
    input int st_lo, input int st_hi,
    input int wr_lo, input int wr_hi, input int dn);
    string t;
    start         = 1'b1;
    num_rows      = 11'(n);
    ub_base_addr  = ubb;
    res_base_addr = resb;
    fifo_empty    = (w > 0);
    step();
    start = 1'b0;
    for (int c = 1; c <= dn + 1; c++) begin
      if (c == w) fifo_empty = 1'b0;
      if (restart && c == 3) begin
        start = 1'b1;
        num_rows = '0;
      end
      if (restart && c == 4) begin
        start = 1'b0;
        num_rows = 11'(n);
      end
      t = $sformatf("%s c%0d", name, c);
      check({t, " pop"}, fifo_read_enable, 32'(c == f));
      check({t, " we_rl"}, we_rl, 32'(c >= rl_lo && c <= rl_hi));
      check({t, " ubv"}, ub_read_valid, 32'(c >= st_lo && c <= st_hi));
      check({t, " wen"}, res_write_enable, 32'(c >= wr_lo && c <= wr_hi));
      check({t, " busy"}, busy, 32'(c <= dn));
      check({t, " done"}, done, 32'(c == dn));
      if (c >= st_lo && c <= st_hi) hold_ub = ubb + 10'(c - st_lo);
      if (c >= wr_lo && c <= wr_hi) hold_res = resb + 10'(c - wr_lo);
      check({t, " ubaddr"}, ub_address, hold_ub);
      check({t, " resaddr"}, res_address, hold_res);
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_rows = '0;
    ub_base_addr = '0;
    res_base_addr = '0;
    fifo_empty = 1'b0;
`ifdef SEQ_ABORT_EN
    abort = 1'b0;
`endif
    hold_ub = '0;
    hold_res = '0;
    #1;
    check("rst busy", busy, 0);
    check("rst pop", fifo_read_enable, 0);
    check("rst we_rl", we_rl, 0);
    check("rst ubv", ub_read_valid, 0);
    check("rst wen", res_write_enable, 0);
    check("rst done", done, 0);
    check("rst ubaddr", ub_address, 0);
    check("rst resaddr", res_address, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // N=4 with an ignored second start during RELOAD
    run_tile("n4", 4, 10'h010, 10'h100, 0, 1'b1,
             1, 2, 17, 18, 21, 52, 55, 56);
    check("n4 ub hold", ub_address, 10'h013);
    check("n4 res hold", res_address, 10'h103);

    // N=40: writes overlap the stream
    run_tile("n40", 40, 10'h010, 10'h100, 0, 1'b0,
             1, 2, 17, 18, 57, 52, 91, 92);
    check("n40 res hold", res_address, 10'h127);

    // FIFO empty for 5 cycles shifts everything by 5
    run_tile("wait", 4, 10'h010, 10'h100, 5, 1'b0,
             6, 7, 22, 23, 26, 57, 60, 61);

    // address wrap at the top of the map
    run_tile("wrap", 4, 10'h3FE, 10'h3FF, 0, 1'b0,
             1, 2, 17, 18, 21, 52, 55, 56);
    check("wrap ub last", ub_address, 10'h001);
    check("wrap res last", res_address, 10'h002);

    // N=0: immediate done, nothing else
    run_tile("n0", 0, 10'h020, 10'h200, 0, 1'b0,
             -1, 1, 0, 1, 0, 1, 0, 1);
    check("n0 ub hold", ub_address, 10'h001);

    // asynchronous reset in the middle of STREAM
    start = 1'b1;
    num_rows = 11'd4;
    ub_base_addr = 10'h010;
    res_base_addr = 10'h100;
    step();
    start = 1'b0;
    for (int c = 1; c < 19; c++) step();
    check("mid ubv", ub_read_valid, 1);
    rst = 1'b1;
    #1;
    check("rst mid busy", busy, 0);
    check("rst mid ubv", ub_read_valid, 0);
    check("rst mid ubaddr", ub_address, 0);
    check("rst mid resaddr", res_address, 0);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      check($sformatf("post rst c%0d done", c), done, 0);
      check($sformatf("post rst c%0d wen", c), res_write_enable, 0);
      check($sformatf("post rst c%0d busy", c), busy, 0);
    end

`ifdef SEQ_ABORT_EN
    abort = 1'b1;
    step();
    check("idle abort", aborted, 0);
    abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    check("ab rl", we_rl, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab pulse", aborted, 1);
    check("ab busy", busy, 0);
    check("ab we_rl", we_rl, 0);
    step();
    check("ab pulse end", aborted, 0);
    check("ab done", done, 0);
    check("ab busy2", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
